calib_line_arbiter: RTL and testbench

//  Shares one calibration-sum datapath (char stream in, per-line digit extraction) between NUM_SRC

---
 rtl/calib_line_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_calib_line_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calib_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : calib_line_arbiter
// Purpose  : Line-atomic arbiter that shares one calibration-sum datapath
//            between NUM_SRC character sources. A winning source keeps the
//            grant until its newline (0x0A) has passed. After every newline
//            the datapath gets GAP_CYCLES idle cycles to close the line.
//            A line that reaches MAX_LINE_LEN characters without a newline is
//            closed with an inserted newline and a timeout_err pulse.
// Ports    : clk, rst (async, active-high)
//            src_valid/src_char/src_ready : per-source char handshake
//            dst_valid/dst_char/dst_ready : char handshake toward datapath
//            grant_id    : current or most recent granted source
//            busy        : high whenever the arbiter is not idle
//            lines_done  : newlines delivered on dst (forced ones included)
//            timeout_err : one-cycle pulse after a forced newline transfer
// Options  : CALIB_ARB_PRIO0_EN - source 0 gets strict priority at each
//            arbitration; the other sources round-robin among themselves.
// Revision : 1.0 - initial release
// ============================================================================
module calib_line_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int MAX_LINE_LEN = 64,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [8*NUM_SRC-1:0]       src_char,
    output logic [NUM_SRC-1:0]         src_ready,
    output logic                       dst_valid,
    output logic [7:0]                 dst_char,
    input  logic                       dst_ready,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic [31:0]                lines_done,
    output logic                       timeout_err
);

    localparam int c_GNT_W = $clog2(NUM_SRC);
    localparam int c_CNT_W = $clog2(MAX_LINE_LEN + 1);
    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [7:0]         c_NEWLINE  = 8'h0A;
    localparam logic [c_GNT_W:0]   c_NUM_SRC  = (c_GNT_W + 1)'(NUM_SRC);
    localparam logic [c_CNT_W-1:0] c_MAX_LEN  = c_CNT_W'(MAX_LINE_LEN);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FORCE  = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_GNT_W-1:0]   r_grant;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic [31:0]          r_lines;
    logic                 r_timeout;
    logic [7:0]           r_last_char;

    logic [7:0]           w_chars [NUM_SRC];
    logic                 w_any;
    logic                 w_skip;
    logic [c_GNT_W-1:0]   w_pick;
    logic [c_GNT_W:0]     w_slot;
    logic                 w_gvalid;
    logic [7:0]           w_gchar;
    logic                 w_xfer;
    logic [c_CNT_W-1:0]   w_cnt_inc;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
        assign w_chars[gi] = src_char[8*gi +: 8];
    end

    // Rotating scan starting one past the last grant; the first requester
    // found wins. The slot sum is one bit wider so the wrap is a subtract.
    always_comb begin
        w_any  = 1'b0;
        w_skip = 1'b0;
        w_pick = r_grant;
        w_slot = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            w_slot = {1'b0, r_grant} + (c_GNT_W + 1)'(i);
            if (w_slot >= c_NUM_SRC) begin
                w_slot = w_slot - c_NUM_SRC;
            end
`ifdef CALIB_ARB_PRIO0_EN
            // Source 0 is handled by the priority override below.
            w_skip = (w_slot == '0);
`else
            w_skip = 1'b0;
`endif
            if (!w_any && !w_skip && src_valid[w_slot[c_GNT_W-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_slot[c_GNT_W-1:0];
            end
        end
`ifdef CALIB_ARB_PRIO0_EN
        if (src_valid[0]) begin
            w_any  = 1'b1;
            w_pick = '0;
        end
`endif
    end

    assign w_gvalid  = src_valid[r_grant];
    assign w_gchar   = w_chars[r_grant];
    assign w_cnt_inc = r_cnt + c_CNT_W'(1);

    // Zero-latency pass-through while streaming. dst_char falls back to the
    // last value actually driven so it never shows an ungranted source.
    always_comb begin
        src_ready = '0;
        dst_valid = 1'b0;
        dst_char  = r_last_char;
        case (r_state)
            ST_STREAM: begin
                dst_valid          = w_gvalid;
                src_ready[r_grant] = dst_ready;
                if (w_gvalid) begin
                    dst_char = w_gchar;
                end
            end
            ST_FORCE: begin
                dst_valid = 1'b1;
                dst_char  = c_NEWLINE;
            end
            default: begin
            end
        endcase
    end

    assign w_xfer = dst_valid & dst_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= c_GNT_W'(NUM_SRC - 1);
            r_cnt       <= '0;
            r_gap_cnt   <= '0;
            r_lines     <= '0;
            r_timeout   <= 1'b0;
            r_last_char <= '0;
        end else begin
            r_timeout <= 1'b0;
            if (dst_valid) begin
                r_last_char <= dst_char;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        if (dst_char == c_NEWLINE) begin
                            r_cnt     <= '0;
                            r_lines   <= r_lines + 32'd1;
                            r_gap_cnt <= '0;
                            r_state   <= ST_GAP;
                        end else begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == c_MAX_LEN) begin
                                r_state <= ST_FORCE;
                            end
                        end
                    end
                end
                ST_FORCE: begin
                    if (w_xfer) begin
                        r_cnt     <= '0;
                        r_lines   <= r_lines + 32'd1;
                        r_timeout <= 1'b1;
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_id    = r_grant;
    assign busy        = (r_state != ST_IDLE);
    assign lines_done  = r_lines;
    assign timeout_err = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_calib_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_calib_line_arbiter
// Purpose  : Self-checking bench for calib_line_arbiter (NUM_SRC=4,
//            MAX_LINE_LEN=64, GAP_CYCLES=1). Source FIFOs are byte queues;
//            a behavioural model predicts every output each cycle and
//            directed scenarios pin the results with literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calib_line_arbiter;

    localparam int c_N   = 4;
    localparam int c_MAX = 64;
    localparam int c_GAP = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [c_N-1:0]   src_valid;
    logic [8*c_N-1:0] src_char;
    logic [c_N-1:0]   src_ready;
    logic             dst_valid;
    logic [7:0]       dst_char;
    logic             dst_ready;
    logic [1:0]       grant_id;
    logic             busy;
    logic [31:0]      lines_done;
    logic             timeout_err;

    calib_line_arbiter #(
        .NUM_SRC      (c_N),
        .MAX_LINE_LEN (c_MAX),
        .GAP_CYCLES   (c_GAP)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid   (src_valid),
        .src_char    (src_char),
        .src_ready   (src_ready),
        .dst_valid   (dst_valid),
        .dst_char    (dst_char),
        .dst_ready   (dst_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .lines_done  (lines_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] q [c_N][$];
    logic [7:0] got [$];
    int         got_gnt [$];
    int         pulses = 0;
    logic [c_N-1:0] hs = '0;
    bit         toggle = 1'b0;

    // Model: who owns the datapath, how far into the line, pending gap.
    int          m_owner;
    bit          m_forcing;
    int          m_gap_left;
    int          m_cnt;
    int          m_last;
    logic [31:0] m_lines;
    bit          m_pulse;
    logic [7:0]  m_char;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner    = -1;
        m_forcing  = 1'b0;
        m_gap_left = 0;
        m_cnt      = 0;
        m_last     = c_N - 1;
        m_lines    = '0;
        m_pulse    = 1'b0;
        m_char     = 8'h00;
    endtask

    function automatic int rr_pick(input logic [c_N-1:0] v, input int last);
        int pick;
        int s;
        pick = -1;
`ifdef CALIB_ARB_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 1; k <= c_N; k++) begin
            s = (last + k) % c_N;
`ifdef CALIB_ARB_PRIO0_EN
            if (s == 0) continue;
`endif
            if (pick < 0 && ((v >> s) & c_N'(1)) != '0) pick = s;
        end
        return pick;
    endfunction

    always @(negedge clk) begin : p_cmp
        logic             e_valid;
        logic [7:0]       e_char;
        logic [c_N-1:0]   e_ready;
        logic [8*c_N-1:0] sh;
        bit               xfer;
        int               p;
        if (rst) begin
            model_reset();
            hs = '0;
        end
        e_valid = 1'b0;
        e_char  = m_char;
        e_ready = '0;
        if (m_forcing) begin
            e_valid = 1'b1;
            e_char  = 8'h0A;
        end else if (m_owner >= 0) begin
            e_valid = ((src_valid >> m_owner) & c_N'(1)) != '0;
            sh      = src_char >> (8 * m_owner);
            if (e_valid) e_char = sh[7:0];
            e_ready = dst_ready ? (c_N'(1) << m_owner) : '0;
        end
        check("dst_valid",   int'(dst_valid),   int'(e_valid));
        check("dst_char",    int'(dst_char),    int'(e_char));
        check("src_ready",   int'(src_ready),   int'(e_ready));
        check("busy",        int'(busy),        int'(m_owner >= 0 || m_gap_left > 0));
        check("grant_id",    int'(grant_id),    m_last);
        check("lines_done",  int'(lines_done),  int'(m_lines));
        check("timeout_err", int'(timeout_err), int'(m_pulse));
        if (!rst) begin
            xfer    = e_valid && dst_ready;
            hs      = src_valid & src_ready;
            m_pulse = 1'b0;
            if (timeout_err) pulses++;
            if (dst_valid && dst_ready) begin
                got.push_back(dst_char);
                got_gnt.push_back(int'(grant_id));
            end
            if (e_valid) m_char = e_char;
            if (m_forcing) begin
                if (xfer) begin
                    m_forcing  = 1'b0;
                    m_lines    = m_lines + 32'd1;
                    m_cnt      = 0;
                    m_pulse    = 1'b1;
                    m_owner    = -1;
                    m_gap_left = c_GAP;
                end
            end else if (m_owner >= 0) begin
                if (xfer) begin
                    m_cnt++;
                    if (e_char == 8'h0A) begin
                        m_lines    = m_lines + 32'd1;
                        m_cnt      = 0;
                        m_owner    = -1;
                        m_gap_left = c_GAP;
                    end else if (m_cnt == c_MAX) begin
                        m_forcing = 1'b1;
                    end
                end
            end else if (m_gap_left > 0) begin
                m_gap_left--;
            end else begin
                p = rr_pick(src_valid, m_last);
                if (p >= 0) begin
                    m_owner = p;
                    m_last  = p;
                end
            end
        end
    end

    task automatic drive();
        logic [c_N-1:0]   v;
        logic [8*c_N-1:0] c;
        v = '0;
        c = '0;
        for (int i = 0; i < c_N; i++) begin
            if (q[i].size() > 0) begin
                v = v | (c_N'(1) << i);
                c = c | ((8*c_N)'(q[i][0]) << (8 * i));
            end
        end
        src_valid = v;
        src_char  = c;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        for (int i = 0; i < c_N; i++) begin
            if (((hs >> i) & c_N'(1)) != '0 && q[i].size() > 0) void'(q[i].pop_front());
        end
        if (toggle) dst_ready = ~dst_ready;
        drive();
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < c_N; i++) if (q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while ((busy || any_pending()) && n < 2000);
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s_timeout: got busy after %0d cycles required idle", name, n);
        end
        cyc();
    endtask

    task automatic clear_logs();
        got.delete();
        got_gnt.delete();
        pulses = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < c_N; i++) q[i].delete();
        toggle    = 1'b0;
        dst_ready = 1'b1;
        drive();
        repeat (2) cyc();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic push_str(input int s, input string str);
        for (int k = 0; k < str.len(); k++) q[s].push_back(str[k]);
    endtask

    initial begin : p_stim
        string e1;
        string e4;
        int    n;
        src_valid = '0;
        src_char  = '0;
        dst_ready = 1'b1;
        model_reset();
        repeat (2) cyc();
        check("rst_busy",       int'(busy),       0);
        check("rst_grant",      int'(grant_id),   3);
        check("rst_lines",      int'(lines_done), 0);
        check("rst_dst_valid",  int'(dst_valid),  0);
        check("rst_src_ready",  int'(src_ready),  0);
        do_reset();

        // T1: single line from source 0
        push_str(0, "a1b2\n");
        drive();
        wait_done("t1");
        e1 = "a1b2\n";
        check("t1_count", got.size(), 5);
        for (int k = 0; k < 5; k++) check("t1_char", int'(got[k]), int'(e1[k]));
        check("t1_grant", int'(grant_id),   0);
        check("t1_lines", int'(lines_done), 1);

        // T2: four sources, one line each, twice
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < c_N; s++) push_str(s, "7\n");
            drive();
            wait_done("t2");
            check("t2_count", got.size(), 8);
            for (int k = 0; k < 8; k++) begin
                check("t2_order", got_gnt[k], k / 2);
                check("t2_char",  int'(got[k]), (k % 2 == 0) ? 32'h37 : 32'h0A);
            end
            check("t2_lines", int'(lines_done), (r == 0) ? 4 : 8);
            clear_logs();
        end

        // T3: runaway line from source 1, then the tail closed by a newline
        do_reset();
        for (int k = 0; k < 70; k++) q[1].push_back(8'(8'h41 + k % 26));
        q[1].push_back(8'h0A);
        drive();
        wait_done("t3");
        check("t3_count",   got.size(), 72);
        check("t3_char63",  int'(got[63]), 32'h4C);
        check("t3_forced",  int'(got[64]), 32'h0A);
        check("t3_char64",  int'(got[65]), 32'h4D);
        check("t3_char69",  int'(got[70]), 32'h52);
        check("t3_newline", int'(got[71]), 32'h0A);
        check("t3_pulses",  pulses, 1);
        check("t3_lines",   int'(lines_done), 2);
        check("t3_grant",   got_gnt[65], 1);

        // T4: dst_ready toggling during "12\n" from source 2
        do_reset();
        toggle = 1'b1;
        push_str(2, "12\n");
        drive();
        wait_done("t4");
        toggle    = 1'b0;
        dst_ready = 1'b1;
        e4 = "12\n";
        check("t4_count", got.size(), 3);
        for (int k = 0; k < 3; k++) check("t4_char", int'(got[k]), int'(e4[k]));
        check("t4_lines", int'(lines_done), 1);
        check("t4_grant", int'(grant_id),   2);

        // T5: reset in the middle of "abc\n"
        clear_logs();
        push_str(2, "abc\n");
        drive();
        n = 0;
        while (got.size() < 2 && n < 100) begin
            cyc();
            n++;
        end
        check("t5_reach", got.size(), 2);
        #1;
        rst = 1'b1;
        #1;
        check("t5_busy",      int'(busy),        0);
        check("t5_dst_valid", int'(dst_valid),   0);
        check("t5_src_ready", int'(src_ready),   0);
        check("t5_lines",     int'(lines_done),  0);
        check("t5_grant",     int'(grant_id),    3);
        check("t5_dst_char",  int'(dst_char),    0);
        check("t5_timeout",   int'(timeout_err), 0);
        for (int i = 0; i < c_N; i++) q[i].delete();
        drive();
        repeat (2) cyc();
        rst = 1'b0;
        clear_logs();
        push_str(0, "x\n");
        push_str(1, "x\n");
        drive();
        wait_done("t5");
        check("t5_first", got_gnt[0], 0);
        check("t5_next",  got_gnt[2], 1);
        check("t5_lines_after", int'(lines_done), 2);

        // T6: sources 0 and 2 continuously requesting
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push_str(0, "5\n");
            push_str(2, "5\n");
        end
        drive();
        wait_done("t6");
        check("t6_count", got.size(), 16);
        for (int k = 0; k < 4; k++) begin
`ifdef CALIB_ARB_PRIO0_EN
            check("t6_order", got_gnt[2*k], 0);
`else
            check("t6_order", got_gnt[2*k], (k % 2 == 0) ? 0 : 2);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
